// File: rtl/ysyx_22041752_sram2axi_pkg.sv
// Shared constants for the SRAM-to-AXI4-Lite bridge.
//   - default address/data widths of the LSU data path
//   - AXI response codes and the constant protection attribute
//   - FSM state encodings, kept as plain logic constants
//   - resp_is_err(): true for any response other than OKAY
package ysyx_22041752_sram2axi_pkg;

    localparam int DEF_ADDR_WD = 32;
    localparam int DEF_DATA_WD = 64;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT = 3'b000;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RADDR = 3'd1;
    localparam logic [2:0] ST_RDATA = 3'd2;
    localparam logic [2:0] ST_WREQ  = 3'd3;
    localparam logic [2:0] ST_WRESP = 3'd4;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_22041752_sram2axi_if.sv
// AXI4-Lite bus bundle between the bridge and the MMIO crossbar.
//   master modport : AW/W/AR valid+payload and B/R ready driven, the rest sampled
//   slave modport  : the mirror image, used by bus models and peripherals
interface ysyx_22041752_sram2axi_if #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 64
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_WD-1:0]     awaddr;
    logic [2:0]             awprot;

    logic                   wvalid;
    logic                   wready;
    logic [DATA_WD-1:0]     wdata;
    logic [DATA_WD/8-1:0]   wstrb;

    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;

    logic                   arvalid;
    logic                   arready;
    logic [ADDR_WD-1:0]     araddr;
    logic [2:0]             arprot;

    logic                   rvalid;
    logic                   rready;
    logic [DATA_WD-1:0]     rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, awprot, input  awready,
        output wvalid,  wdata,  wstrb,  input  wready,
        input  bvalid,  bresp,          output bready,
        output arvalid, araddr, arprot, input  arready,
        input  rvalid,  rdata,  rresp,  output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid,  wdata,  wstrb,  output wready,
        output bvalid,  bresp,          input  bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid,  rdata,  rresp,  input  rready
    );

endinterface

// File: rtl/ysyx_22041752_sram2axi.sv
// SRAM-like request to AXI4-Lite master bridge.
// One request from the LSU IO bridge becomes exactly one AXI4-Lite read or
// write; only one transaction is ever outstanding.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   sram_req       request strobe (wen/addr/wdata sampled with it in IDLE)
//   sram_ready     registered one-cycle accept pulse
//   sram_wen       1 = write, 0 = read
//   sram_addr      access address
//   sram_wdata     write data
//   sram_rdata     read data, held until the next read completes
//   sram_valid     registered one-cycle completion pulse (reads and writes)
//   m_axi          AXI4-Lite master bundle
//   bus_err        sticky error flag: any non-OKAY B or R response
module ysyx_22041752_sram2axi
    import ysyx_22041752_sram2axi_pkg::*;
#(
    parameter int ADDR_WD = DEF_ADDR_WD,
    parameter int DATA_WD = DEF_DATA_WD
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic                        sram_req,
    output logic                        sram_ready,
    input  logic                        sram_wen,
    input  logic [ADDR_WD-1:0]          sram_addr,
    input  logic [DATA_WD-1:0]          sram_wdata,
    output logic [DATA_WD-1:0]          sram_rdata,
    output logic                        sram_valid,

    ysyx_22041752_sram2axi_if.master    m_axi,

    output logic                        bus_err
);

    logic [2:0]         state_q,   state_d;
    logic [ADDR_WD-1:0] addr_q,    addr_d;
    logic [DATA_WD-1:0] wdata_q,   wdata_d;
    logic [DATA_WD-1:0] rdata_q,   rdata_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q,  w_done_d;
    logic               ready_q,   ready_d;
    logic               valid_q,   valid_d;
    logic               bus_err_q, bus_err_d;

    // Every AXI valid/ready is a pure function of flops, so no valid ever
    // depends combinationally on the slave's ready.
    assign m_axi.arvalid = (state_q == ST_RADDR);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = AXI_PROT;
    assign m_axi.rready  = (state_q == ST_RDATA);

    assign m_axi.awvalid = (state_q == ST_WREQ) && !aw_done_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = AXI_PROT;
    assign m_axi.wvalid  = (state_q == ST_WREQ) && !w_done_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.bready  = (state_q == ST_WRESP);

    assign sram_ready = ready_q;
    assign sram_valid = valid_q;
    assign sram_rdata = rdata_q;
    assign bus_err    = bus_err_q;

    always_comb begin
        // NOTE: every _d starts from its flop (or 0 for pulses) so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ready_d   = 1'b0;
        valid_d   = 1'b0;
        bus_err_d = bus_err_q;

        case (state_q)
            ST_IDLE: begin
                if (sram_req) begin
                    addr_d  = sram_addr;
                    ready_d = 1'b1;
                    if (sram_wen) begin
                        wdata_d   = sram_wdata;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = ST_WREQ;
                    end else begin
                        state_d   = ST_RADDR;
                    end
                end
            end

            ST_RADDR: begin
                if (m_axi.arready) begin
                    state_d = ST_RDATA;
                end
            end

            ST_RDATA: begin
                if (m_axi.rvalid) begin
                    rdata_d   = m_axi.rdata;
                    valid_d   = 1'b1;
                    bus_err_d = bus_err_q | resp_is_err(m_axi.rresp);
                    state_d   = ST_IDLE;
                end
            end

            ST_WREQ: begin
                // AW and W complete independently; a channel whose done flag
                // is already set has its valid low, so its ready is a no-op.
                aw_done_d = aw_done_q | m_axi.awready;
                w_done_d  = w_done_q  | m_axi.wready;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end
            end

            ST_WRESP: begin
                if (m_axi.bvalid) begin
                    valid_d   = 1'b1;
                    bus_err_d = bus_err_q | resp_is_err(m_axi.bresp);
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the address/data registers are reset too; they are few and a
    // known value on awaddr/araddr/rdata after reset eases debug.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // same pre-edge values.
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041752_sram2axi.sv
// Self-checking bench for ysyx_22041752_sram2axi.
// Inputs are driven and outputs sampled on the falling edge; the AXI slave is
// played by the bench itself. Completions are checked against a queue of
// expected results pushed when each request is issued.
module tb_ysyx_22041752_sram2axi;
    import ysyx_22041752_sram2axi_pkg::*;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam logic [AW-1:0] RND_BASE = 32'h8000_0000;
    localparam int NUM_RND = 1000;

    typedef struct {
        logic          is_read;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          sram_req;
    logic          sram_ready;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
    logic          sram_valid;
    logic          bus_err;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errs    = 0;

    ysyx_22041752_sram2axi_if #(.ADDR_WD(AW), .DATA_WD(DW)) axi ();

    ysyx_22041752_sram2axi #(.ADDR_WD(AW), .DATA_WD(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sram_req   (sram_req),
        .sram_ready (sram_ready),
        .sram_wen   (sram_wen),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_valid (sram_valid),
        .m_axi      (axi.master),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic slave_idle;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.arready = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = AXI_RESP_OKAY;
        axi.rvalid  = 1'b0;
        axi.rdata   = '0;
        axi.rresp   = AXI_RESP_OKAY;
    endtask

    task automatic test_reset;
        logic [7:0] outs;
        reset = 1'b1;
        sram_req = 1'b0; sram_wen = 1'b0; sram_addr = '0; sram_wdata = '0;
        slave_idle();
        @(negedge clk);
        @(negedge clk);
        outs = {sram_ready, sram_valid, bus_err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready};
        vectors++; if (outs !== 8'h00) begin errs++; $display("FAIL rst_ctrl got %b want 00000000", outs); end
        vectors++; if (sram_rdata !== '0) begin errs++; $display("FAIL rst_rdata got %h want 0", sram_rdata); end
        vectors++; if (axi.araddr !== '0 || axi.wdata !== '0) begin errs++; $display("FAIL rst_regs araddr %h wdata %h want 0", axi.araddr, axi.wdata); end
        reset = 1'b0;
        tick();
        outs = {sram_ready, sram_valid, bus_err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready};
        vectors++; if (outs !== 8'h00) begin errs++; $display("FAIL rst_idle got %b want 00000000", outs); end
    endtask

    // Zero-wait read with per-cycle latency checks.
    task automatic test_read_zero_wait;
        exp_t e;
        exp_q.push_back('{1'b1, 64'h0000_0000_1234_5678});
        sram_req = 1'b1; sram_wen = 1'b0; sram_addr = 32'ha000_0048;
        vectors++; if (axi.arvalid !== 1'b0) begin errs++; $display("FAIL rd_ar_c0 got %b want 0", axi.arvalid); end
        tick(); // cycle 1
        sram_req = 1'b0;
        vectors++; if (sram_ready !== 1'b1) begin errs++; $display("FAIL rd_ready_c1 got %b want 1", sram_ready); end
        vectors++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'ha000_0048) begin errs++; $display("FAIL rd_ar_c1 valid %b addr %h want 1 a0000048", axi.arvalid, axi.araddr); end
        vectors++; if (axi.arprot !== 3'b000) begin errs++; $display("FAIL rd_arprot got %b want 000", axi.arprot); end
        axi.arready = 1'b1;
        tick(); // cycle 2
        axi.arready = 1'b0;
        vectors++; if ({axi.arvalid, axi.rready, sram_ready} !== 3'b010) begin errs++; $display("FAIL rd_c2 ar/r/ready got %b want 010", {axi.arvalid, axi.rready, sram_ready}); end
        axi.rvalid = 1'b1; axi.rdata = 64'h0000_0000_1234_5678; axi.rresp = AXI_RESP_OKAY;
        tick(); // cycle 3
        axi.rvalid = 1'b0; axi.rdata = 64'hffff_ffff_ffff_ffff;
        vectors++;
        if (sram_valid !== 1'b1 || exp_q.size() == 0) begin
            errs++; $display("FAIL rd_valid_c3 got %b want 1 (queue %0d)", sram_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (sram_rdata !== e.data) begin errs++; $display("FAIL rd_data got %h want %h", sram_rdata, e.data); end
        end
        vectors++; if (axi.rready !== 1'b0) begin errs++; $display("FAIL rd_rready_c3 got %b want 0", axi.rready); end
        tick();
        vectors++; if (sram_valid !== 1'b0 || sram_rdata !== 64'h1234_5678) begin errs++; $display("FAIL rd_hold valid %b data %h want 0 0000000012345678", sram_valid, sram_rdata); end
    endtask

    // Write: AW accepted at cycle 1, W held until cycle 4, B at cycle 6.
    task automatic test_write_w_late;
        exp_q.push_back('{1'b0, '0});
        sram_req = 1'b1; sram_wen = 1'b1; sram_addr = 32'ha000_0100; sram_wdata = 64'hdeadbeef_cafef00d;
        tick(); // 1
        sram_req = 1'b0; sram_wdata = '0;
        vectors++; if (sram_ready !== 1'b1) begin errs++; $display("FAIL wr_ready_c1 got %b want 1", sram_ready); end
        vectors++; if ({axi.awvalid, axi.wvalid} !== 2'b11 || axi.awaddr !== 32'ha000_0100) begin errs++; $display("FAIL wr_c1 aw/w %b addr %h want 11 a0000100", {axi.awvalid, axi.wvalid}, axi.awaddr); end
        vectors++; if (axi.wdata !== 64'hdeadbeef_cafef00d || axi.wstrb !== 8'hff) begin errs++; $display("FAIL wr_wpayload data %h strb %h want deadbeefcafef00d ff", axi.wdata, axi.wstrb); end
        axi.awready = 1'b1;
        tick(); // 2
        axi.awready = 1'b0;
        vectors++; if ({axi.awvalid, axi.wvalid} !== 2'b01) begin errs++; $display("FAIL wr_c2 aw/w got %b want 01", {axi.awvalid, axi.wvalid}); end
        tick(); // 3
        vectors++; if (axi.wvalid !== 1'b1 || axi.wdata !== 64'hdeadbeef_cafef00d) begin errs++; $display("FAIL wr_c3 wvalid %b wdata %h want 1 deadbeefcafef00d", axi.wvalid, axi.wdata); end
        tick(); // 4
        vectors++; if ({axi.wvalid, axi.bready} !== 2'b10) begin errs++; $display("FAIL wr_c4 w/b got %b want 10", {axi.wvalid, axi.bready}); end
        axi.wready = 1'b1;
        tick(); // 5
        axi.wready = 1'b0;
        vectors++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin errs++; $display("FAIL wr_c5 aw/w/b got %b want 001", {axi.awvalid, axi.wvalid, axi.bready}); end
        tick(); // 6
        vectors++; if (axi.bready !== 1'b1 || sram_valid !== 1'b0) begin errs++; $display("FAIL wr_c6 bready %b valid %b want 1 0", axi.bready, sram_valid); end
        axi.bvalid = 1'b1; axi.bresp = AXI_RESP_OKAY;
        tick(); // 7
        axi.bvalid = 1'b0;
        vectors++;
        if (sram_valid !== 1'b1 || exp_q.size() == 0) begin
            errs++; $display("FAIL wr_valid_c7 got %b want 1 (queue %0d)", sram_valid, exp_q.size());
        end else begin
            void'(exp_q.pop_front());
        end
        vectors++; if (bus_err !== 1'b0 || sram_rdata !== 64'h1234_5678) begin errs++; $display("FAIL wr_side bus_err %b rdata %h want 0 0000000012345678", bus_err, sram_rdata); end
        tick();
        vectors++; if (sram_valid !== 1'b0) begin errs++; $display("FAIL wr_valid_pulse got %b want 0", sram_valid); end
    endtask

    // Write: W accepted at cycle 1, AW at cycle 3, WRESP from cycle 4.
    task automatic test_write_w_first;
        exp_q.push_back('{1'b0, '0});
        sram_req = 1'b1; sram_wen = 1'b1; sram_addr = 32'ha000_0200; sram_wdata = 64'h0123_4567_89ab_cdef;
        tick(); // 1
        sram_req = 1'b0;
        axi.wready = 1'b1;
        tick(); // 2
        axi.wready = 1'b0;
        vectors++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin errs++; $display("FAIL wf_c2 aw/w/b got %b want 100", {axi.awvalid, axi.wvalid, axi.bready}); end
        tick(); // 3
        vectors++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b100) begin errs++; $display("FAIL wf_c3 aw/w/b got %b want 100", {axi.awvalid, axi.wvalid, axi.bready}); end
        axi.awready = 1'b1;
        tick(); // 4
        axi.awready = 1'b0;
        vectors++; if ({axi.awvalid, axi.wvalid, axi.bready} !== 3'b001) begin errs++; $display("FAIL wf_c4 aw/w/b got %b want 001", {axi.awvalid, axi.wvalid, axi.bready}); end
        axi.bvalid = 1'b1;
        tick(); // 5
        axi.bvalid = 1'b0;
        vectors++;
        if (sram_valid !== 1'b1 || exp_q.size() == 0) begin
            errs++; $display("FAIL wf_valid got %b want 1 (queue %0d)", sram_valid, exp_q.size());
        end else begin
            void'(exp_q.pop_front());
        end
        tick();
    endtask

    task automatic simple_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
        exp_t e;
        exp_q.push_back('{1'b1, d});
        sram_req = 1'b1; sram_wen = 1'b0; sram_addr = a;
        tick();
        sram_req = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        axi.rvalid = 1'b1; axi.rdata = d; axi.rresp = resp;
        tick();
        axi.rvalid = 1'b0; axi.rresp = AXI_RESP_OKAY;
        vectors++;
        if (sram_valid !== 1'b1 || exp_q.size() == 0) begin
            errs++; $display("FAIL srd_valid addr %h got %b want 1", a, sram_valid);
        end else begin
            e = exp_q.pop_front();
            if (sram_rdata !== e.data) begin errs++; $display("FAIL srd_data addr %h got %h want %h", a, sram_rdata, e.data); end
        end
        tick();
    endtask

    task automatic simple_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] resp);
        exp_q.push_back('{1'b0, '0});
        sram_req = 1'b1; sram_wen = 1'b1; sram_addr = a; sram_wdata = d;
        tick();
        sram_req = 1'b0;
        axi.awready = 1'b1; axi.wready = 1'b1;
        tick();
        axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b1; axi.bresp = resp;
        tick();
        axi.bvalid = 1'b0; axi.bresp = AXI_RESP_OKAY;
        vectors++;
        if (sram_valid !== 1'b1 || exp_q.size() == 0) begin
            errs++; $display("FAIL swr_valid addr %h got %b want 1", a, sram_valid);
        end else begin
            void'(exp_q.pop_front());
        end
        tick();
    endtask

    task automatic test_read_slverr;
        vectors++; if (bus_err !== 1'b0) begin errs++; $display("FAIL err_pre got %b want 0", bus_err); end
        simple_read(32'ha000_0300, 64'hbad0_bad0_bad0_bad0, AXI_RESP_SLVERR);
        vectors++; if (bus_err !== 1'b1) begin errs++; $display("FAIL err_set got %b want 1", bus_err); end
        simple_read(32'ha000_0308, 64'h1111_2222_3333_4444, AXI_RESP_OKAY);
        simple_write(32'ha000_0310, 64'h5555_6666_7777_8888, AXI_RESP_OKAY);
        vectors++; if (bus_err !== 1'b1) begin errs++; $display("FAIL err_sticky got %b want 1", bus_err); end
    endtask

    // Random stalls on every channel; the slave keeps its own memory written
    // only through AXI, the reference memory is updated when a write is issued.
    task automatic test_back_to_back;
        logic [DW-1:0] ref_mem [16];
        logic [DW-1:0] slv_mem [16];
        int issued, done, gap, cyc, idx;
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        bit busy, wait_ready, got_aw, got_w, got_ar;
        bit s_aw, s_w, s_ar, s_b, s_r;
        logic [AW-1:0] s_awaddr, s_araddr, aw_addr_c, ar_addr_c;
        logic [DW-1:0] s_wdata, w_data_c, wd;
        logic [DW/8-1:0] s_wstrb;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = {32'h5eed_0000 + 32'(i), 32'h0f0f_0000 + 32'(i)};
            slv_mem[i] = ref_mem[i];
        end
        issued = 0; done = 0; gap = 0; cyc = 0;
        busy = 0; wait_ready = 0; got_aw = 0; got_w = 0; got_ar = 0;
        s_aw = 0; s_w = 0; s_ar = 0; s_b = 0; s_r = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        aw_addr_c = '0; ar_addr_c = '0; w_data_c = '0;
        aw_cnt = 0; w_cnt = 2; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        while (done < NUM_RND && cyc < 60000) begin
            // Handshakes completed at the edge just passed.
            if (s_aw) begin
                got_aw = 1; aw_addr_c = s_awaddr; aw_cnt = $urandom_range(5, 0);
                vectors++; if ((s_awaddr & ~32'h78) !== RND_BASE) begin errs++; $display("FAIL rnd_awaddr got %h", s_awaddr); end
            end
            if (s_w) begin
                got_w = 1; w_data_c = s_wdata; w_cnt = $urandom_range(5, 0);
                vectors++; if (s_wstrb !== 8'hff) begin errs++; $display("FAIL rnd_wstrb got %h want ff", s_wstrb); end
            end
            if (s_ar) begin
                got_ar = 1; ar_addr_c = s_araddr; ar_cnt = $urandom_range(5, 0);
                vectors++; if ((s_araddr & ~32'h78) !== RND_BASE) begin errs++; $display("FAIL rnd_araddr got %h", s_araddr); end
            end
            if (s_b) begin axi.bvalid = 1'b0; got_aw = 0; got_w = 0; b_cnt = $urandom_range(5, 0); end
            if (s_r) begin axi.rvalid = 1'b0; r_cnt = $urandom_range(5, 0); end

            // Upstream-facing outputs.
            if (sram_ready) begin
                vectors++; if (!wait_ready) begin errs++; $display("FAIL rnd_ready unexpected pulse at txn %0d", issued); end
                wait_ready = 0; sram_req = 1'b0;
            end
            if (sram_valid) begin
                vectors++;
                if (!busy || wait_ready || exp_q.size() == 0) begin
                    errs++; $display("FAIL rnd_valid unexpected pulse at txn %0d", done);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read && sram_rdata !== e.data) begin errs++; $display("FAIL rnd_rdata txn %0d got %h want %h", done, sram_rdata, e.data); end
                    busy = 0; done++;
                    gap = (done == 1) ? 2 : int'($urandom_range(5, 0));
                end
            end

            // Slave responses.
            axi.awready = axi.awvalid && (aw_cnt == 0);
            if (axi.awvalid && aw_cnt > 0) aw_cnt--;
            axi.wready = axi.wvalid && (w_cnt == 0);
            if (axi.wvalid && w_cnt > 0) w_cnt--;
            axi.arready = axi.arvalid && (ar_cnt == 0);
            if (axi.arvalid && ar_cnt > 0) ar_cnt--;
            if (got_aw && got_w && !axi.bvalid) begin
                if (b_cnt == 0) begin
                    axi.bvalid = 1'b1; axi.bresp = AXI_RESP_OKAY;
                    slv_mem[int'(aw_addr_c[6:3])] = w_data_c;
                end else b_cnt--;
            end
            if (got_ar && !axi.rvalid) begin
                if (r_cnt == 0) begin
                    axi.rvalid = 1'b1; axi.rresp = AXI_RESP_OKAY;
                    axi.rdata = slv_mem[int'(ar_addr_c[6:3])];
                    got_ar = 0;
                end else r_cnt--;
            end

            // Upstream requests: first a read, then a write two cycles after it completes.
            if (!busy && issued < NUM_RND) begin
                if (gap == 0) begin
                    idx = $urandom_range(15, 0);
                    sram_wen = (issued == 0) ? 1'b0 : (issued == 1) ? 1'b1 : 1'($urandom_range(1, 0));
                    sram_addr = RND_BASE + 32'(idx * 8);
                    wd = {$urandom(), $urandom()};
                    sram_wdata = wd;
                    if (sram_wen) begin
                        ref_mem[idx] = wd;
                        exp_q.push_back('{1'b0, '0});
                    end else begin
                        exp_q.push_back('{1'b1, ref_mem[idx]});
                    end
                    sram_req = 1'b1; busy = 1; wait_ready = 1; issued++;
                end else gap--;
            end

            // These are all flop-driven, so they hold until the next edge.
            s_aw = axi.awvalid && axi.awready; s_awaddr = axi.awaddr;
            s_w  = axi.wvalid && axi.wready;   s_wdata = axi.wdata; s_wstrb = axi.wstrb;
            s_ar = axi.arvalid && axi.arready; s_araddr = axi.araddr;
            s_b  = axi.bvalid && axi.bready;
            s_r  = axi.rvalid && axi.rready;
            tick();
            cyc++;
        end
        vectors++; if (done != NUM_RND || exp_q.size() != 0) begin errs++; $display("FAIL rnd_done got %0d txns (queue %0d) want %0d", done, exp_q.size(), NUM_RND); end
        sram_req = 1'b0;
        slave_idle();
        tick();
    endtask

    task automatic test_reset_mid;
        logic [7:0] outs;
        sram_req = 1'b1; sram_wen = 1'b0; sram_addr = 32'ha000_0400;
        tick();
        sram_req = 1'b0;
        axi.arready = 1'b1;
        tick();
        axi.arready = 1'b0;
        vectors++; if (axi.rready !== 1'b1) begin errs++; $display("FAIL rm_rdata rready got %b want 1", axi.rready); end
        reset = 1'b1;
        tick();
        outs = {sram_ready, sram_valid, bus_err, axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready};
        vectors++; if (outs !== 8'h00) begin errs++; $display("FAIL rm_outs got %b want 00000000", outs); end
        vectors++; if (sram_rdata !== '0) begin errs++; $display("FAIL rm_rdata got %h want 0", sram_rdata); end
        reset = 1'b0;
        tick();
        simple_read(32'ha000_0408, 64'hfeed_face_0bad_cafe, AXI_RESP_OKAY);
        vectors++; if (bus_err !== 1'b0) begin errs++; $display("FAIL rm_buserr got %b want 0", bus_err); end
        simple_write(32'ha000_0410, 64'h0, AXI_RESP_DECERR);
        vectors++; if (bus_err !== 1'b1) begin errs++; $display("FAIL rm_decerr got %b want 1", bus_err); end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_w_late();
        test_write_w_first();
        test_read_slverr();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
